// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback formatting: drives the register-file
// write port and keeps a retired-instruction counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wbsel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  output logic             we,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  wd,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  logic             r_valid;
  logic             r_regwrite;
  logic [4:0]       r_rd;
  logic [1:0]       r_wbsel;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_pc4;
  logic [CNT_W-1:0] r_cnt;

  logic             w_legal;
  logic             w_retire;

  function automatic logic is_legal(input logic [1:0] wbsel, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (wbsel)
      WB_ALU, WB_LINK: ok = 1'b1;
      WB_LOAD: ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lane select and extension of the raw memory word; illegal sizes yield 0.
  function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [XLEN-1:0] word);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [XLEN-1:0]    res;
    case (a)
      2'd0:    sb = word[7:0];
      2'd1:    sb = word[15:8];
      2'd2:    sb = word[23:16];
      default: sb = word[31:24];
    endcase
    sh = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{(XLEN-8){sb[7]}}, sb};
      3'b100:  res = {{(XLEN-8){1'b0}}, sb};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh};
      3'b010:  res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Stage register: flush beats stall, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wbsel    <= '0;
      r_funct3   <= '0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      if (flush) begin
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_valid    <= in_valid;
        r_regwrite <= in_regwrite;
        r_rd       <= in_rd;
        r_wbsel    <= in_wbsel;
        r_funct3   <= in_funct3;
        r_alu      <= in_alu_result;
        r_rdata    <= in_mem_rdata;
        r_pc4      <= in_pc_plus4;
      end
    end
  end

  assign w_legal  = is_legal(r_wbsel, r_funct3);
  assign w_retire = r_valid & ~stall;

  always_comb begin
    wd = '0;
    case (r_wbsel)
      WB_ALU:  wd = r_alu;
      WB_LOAD: wd = load_fmt(r_funct3, r_alu[1:0], r_rdata);
      WB_LINK: wd = r_pc4;
      default: wd = '0;
    endcase
  end

  // A stalled entry writes only in the cycle it is released.
  assign we            = w_retire & r_regwrite & (r_rd != 5'd0) & w_legal;
  assign rd            = r_valid ? r_rd : 5'd0;
  assign wb_valid      = w_retire;
  assign retired_count = r_cnt;

endmodule
